// File: rtl/ipg_reply_packer.sv
// ipg_reply_packer
//   Buffers 64-bit reply chunks from the IPG request processor and slices them
//   into the variable-size inter-packet-gap slots the TX PCS offers each cycle.
//   Output is MSB-aligned payload plus a bit length, matching the RX format.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   reply_chunk  reply chunk, byte 0 in [63:56] goes out first
//   reply_valid  reply_chunk valid this cycle
//   reply_ready  FIFO can take a chunk (not full); accept on valid && ready
//   tx_gap_len   IPG bits free in the current TX word; low 3 bits ignored
//   tx_ipg_data  registered gap payload, MSB-aligned, zero below tx_ipg_len
//   tx_ipg_len   registered number of bits filled (multiple of 8)
//   busy         registered: FIFO or shift buffer holds data after this edge
module ipg_reply_packer #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] reply_chunk,
  input  logic                  reply_valid,
  output logic                  reply_ready,
  input  logic [LEN_WIDTH-1:0]  tx_gap_len,
  output logic [DATA_WIDTH-1:0] tx_ipg_data,
  output logic [LEN_WIDTH-1:0]  tx_ipg_len,
  output logic                  busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam int SBW = 2 * DATA_WIDTH;

  // Reply-chunk FIFO
  logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           fifo_cnt_q, fifo_cnt_d;

  // Shift buffer: valid bytes packed from the MSB, everything below is zero
  logic [SBW-1:0]        sb_q, sb_d;
  logic [4:0]            sb_cnt_q, sb_cnt_d;

  logic [DATA_WIDTH-1:0] tx_ipg_data_q, tx_ipg_data_d;
  logic [LEN_WIDTH-1:0]  tx_ipg_len_q, tx_ipg_len_d;
  logic                  busy_q, busy_d;

  logic                  push;
  logic                  pop;
  logic [2:0]            gap_b;
  logic [2:0]            n;
  logic [4:0]            r;
  logic [DATA_WIDTH-1:0] keep_mask;
  logic [SBW-1:0]        sb_shift;
  logic                  unused_gap_lsbs;

  // Sub-byte gap bits cannot carry payload.
  assign unused_gap_lsbs = ^tx_gap_len[2:0];

  // No pass-through: a full FIFO refuses even if it pops on the same edge.
  assign reply_ready = (fifo_cnt_q != FULL_CNT);

  always_comb begin
    push = reply_valid && reply_ready;

    gap_b = tx_gap_len[5:3];
    n     = ({2'b00, gap_b} < sb_cnt_q) ? gap_b : sb_cnt_q[2:0];

    // Keep the top n bytes of the head word, zero the rest.
    keep_mask     = ~({DATA_WIDTH{1'b1}} >> {n, 3'b000});
    tx_ipg_data_d = sb_q[SBW-1:DATA_WIDTH] & keep_mask;
    tx_ipg_len_d  = LEN_WIDTH'({n, 3'b000});

    sb_shift = sb_q << {n, 3'b000};
    r        = sb_cnt_q - {2'b00, n};

    // Refill only when a whole chunk fits behind the remaining bytes.
    pop      = (r <= 5'd8) && (fifo_cnt_q != '0);
    sb_d     = sb_shift;
    sb_cnt_d = r;
    if (pop) begin
      sb_d     = sb_shift | ({fifo_mem_q[rd_ptr_q], {DATA_WIDTH{1'b0}}} >> {r, 3'b000});
      sb_cnt_d = r + 5'd8;
    end

    wr_ptr_d   = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + (AW+1)'(1);
    end else if (pop && !push) begin
      fifo_cnt_d = fifo_cnt_q - (AW+1)'(1);
    end

    busy_d = (fifo_cnt_d != '0) || (sb_cnt_d != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      sb_q          <= '0;
      sb_cnt_q      <= 5'd0;
      tx_ipg_data_q <= '0;
      tx_ipg_len_q  <= '0;
      busy_q        <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      sb_q          <= sb_d;
      sb_cnt_q      <= sb_cnt_d;
      tx_ipg_data_q <= tx_ipg_data_d;
      tx_ipg_len_q  <= tx_ipg_len_d;
      busy_q        <= busy_d;
    end
  end

  // Storage only; pointers and count carry the reset state.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= reply_chunk;
    end
  end

  assign tx_ipg_data = tx_ipg_data_q;
  assign tx_ipg_len  = tx_ipg_len_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ipg_reply_packer.sv
module tb_ipg_reply_packer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [63:0] reply_chunk;
  logic        reply_valid;
  logic        reply_ready;
  logic [5:0]  tx_gap_len;
  logic [63:0] tx_ipg_data;
  logic [5:0]  tx_ipg_len;
  logic        busy;

  int checks;
  int failures;
  int dut_acc;

  // Reference model: FIFO as a queue of chunks, shift buffer as a queue of bytes
  logic [63:0]  fq[$];
  byte unsigned sbq[$];

  ipg_reply_packer #(.DATA_WIDTH(64), .LEN_WIDTH(6), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .reply_chunk(reply_chunk),
    .reply_valid(reply_valid),
    .reply_ready(reply_ready),
    .tx_gap_len(tx_gap_len),
    .tx_ipg_data(tx_ipg_data),
    .tx_ipg_len(tx_ipg_len),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic step(input logic v, input logic [63:0] ch, input logic [5:0] gap);
    int          n;
    logic [63:0] exp_d;
    logic [63:0] c;
    bit          acc;
    reply_valid = v;
    reply_chunk = ch;
    tx_gap_len  = gap;
    chk("ready_pre", {63'd0, reply_ready}, {63'd0, (fq.size() < DEPTH)});
    acc = v && (fq.size() < DEPTH);
    if (v && reply_ready) dut_acc++;
    n = gap / 8;
    if (n > sbq.size()) n = sbq.size();
    exp_d = '0;
    for (int i = 0; i < n; i++) exp_d[63-8*i -: 8] = sbq.pop_front();
    if (sbq.size() <= 8 && fq.size() > 0) begin
      c = fq.pop_front();
      for (int i = 0; i < 8; i++) sbq.push_back(c[63-8*i -: 8]);
    end
    if (acc) fq.push_back(ch);
    @(posedge clk);
    #1;
    chk("data", tx_ipg_data, exp_d);
    chk("len", {58'd0, tx_ipg_len}, 64'(n * 8));
    chk("busy", {63'd0, busy}, {63'd0, (fq.size() + sbq.size()) != 0});
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    reply_valid = 1'b0;
    reply_chunk = '0;
    tx_gap_len  = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fq.delete();
    sbq.delete();
    chk("rst_data", tx_ipg_data, 64'd0);
    chk("rst_len", {58'd0, tx_ipg_len}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready", {63'd0, reply_ready}, 64'd1);
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 64'd0, 6'd56);
  endtask

  initial begin
    clk         = 1'b0;
    checks      = 0;
    failures    = 0;
    dut_acc     = 0;
    rst         = 1'b1;
    reply_valid = 1'b0;
    reply_chunk = '0;
    tx_gap_len  = '0;
    @(posedge clk);
    do_reset();

    // Single chunk through a 7-byte gap
    step(1'b1, 64'h1122334455667788, 6'd56);
    step(1'b0, 64'd0, 6'd56);
    step(1'b0, 64'd0, 6'd56);
    chk("t1_first", tx_ipg_data, 64'h1122334455667700);
    chk("t1_first_len", {58'd0, tx_ipg_len}, 64'd56);
    step(1'b0, 64'd0, 6'd56);
    chk("t1_second", tx_ipg_data, 64'h8800000000000000);
    chk("t1_second_len", {58'd0, tx_ipg_len}, 64'd8);
    step(1'b0, 64'd0, 6'd56);
    chk("t1_idle_busy", {63'd0, busy}, 64'd0);

    // Gap spanning two chunks
    step(1'b1, 64'h1122334455667788, 6'd24);
    step(1'b1, 64'h99AABBCCDDEEFF00, 6'd24);
    step(1'b0, 64'd0, 6'd24);
    chk("t2_first", tx_ipg_data, 64'h1122330000000000);
    step(1'b0, 64'd0, 6'd24);
    step(1'b0, 64'd0, 6'd24);
    chk("t2_span", tx_ipg_data, 64'h7788990000000000);
    for (int i = 0; i < 4; i++) step(1'b0, 64'd0, 6'd24);

    // Stalls between partial reads
    step(1'b1, 64'h0123456789ABCDEF, 6'd0);
    for (int i = 0; i < 12; i++) step(1'b0, 64'd0, (i % 2 == 0) ? 6'd16 : 6'd0);

    // Fill to capacity with no gap, then drain
    dut_acc = 0;
    for (int i = 0; i < 10; i++) step(1'b1, {32'hC0DE0000 + 32'(i), 32'h5A5A0000 + 32'(i)}, 6'd0);
    chk("t4_accepted", 64'(dut_acc), 64'd6);
    chk("t4_ready_low", {63'd0, reply_ready}, 64'd0);
    drain(12);
    chk("t4_ready_back", {63'd0, reply_ready}, 64'd1);
    chk("t4_busy_done", {63'd0, busy}, 64'd0);

    // Non-byte-multiple gap
    step(1'b1, 64'hA1A2A3A4A5A6A7A8, 6'd0);
    step(1'b0, 64'd0, 6'd0);
    step(1'b0, 64'd0, 6'd20);
    chk("t5_len", {58'd0, tx_ipg_len}, 64'd16);
    chk("t5_data", tx_ipg_data, 64'hA1A2000000000000);
    step(1'b0, 64'd0, 6'd8);
    chk("t5_next", tx_ipg_data, 64'hA300000000000000);
    drain(3);

    // Reset mid-chunk, then a fresh chunk starts at byte 0
    step(1'b1, 64'hDEADBEEFCAFEF00D, 6'd24);
    step(1'b1, 64'h0102030405060708, 6'd24);
    step(1'b0, 64'd0, 6'd24);
    do_reset();
    step(1'b1, 64'h1234567890ABCDEF, 6'd56);
    step(1'b0, 64'd0, 6'd56);
    step(1'b0, 64'd0, 6'd56);
    chk("t6_restart", tx_ipg_data, 64'h1234567890ABCD00);
    drain(3);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
           {$urandom, $urandom},
           6'($urandom_range(0, 63)));
    end
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
